// File: rtl/fb_pixel_packer.sv
// Packs a raster-order 1-bpp pixel stream into 32-bit framebuffer words and
// issues them as held write requests that honour waitrequest.
module fb_pixel_packer #(
    parameter int unsigned WORDS_PER_FRAME = 9600,
    parameter int unsigned ADDR_W          = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic              pix_data,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] fb_address,
    output logic [31:0]       fb_writedata,
    output logic              fb_write,
    input  logic              fb_waitrequest,
    output logic              frame_done,
    output logic              short_frame
);

    typedef enum logic {StIdle, StPend} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS_PER_FRAME - 1);

    state_e            state_q, state_d;
    logic [31:0]       pack_q, pack_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] pack_addr_q, pack_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              short_frame_q, short_frame_d;

    logic accept;
    logic wr_acc;

    // Stall only when the output slot is busy and the next pixel would complete a word.
    assign pix_ready = !((state_q == StPend) && (bit_cnt_q == 5'd31));
    assign accept    = pix_valid && pix_ready;
    assign wr_acc    = (state_q == StPend) && !fb_waitrequest;

    always_comb begin
        state_d       = state_q;
        pack_d        = pack_q;
        bit_cnt_d     = bit_cnt_q;
        pack_addr_d   = pack_addr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;

        if (wr_acc) begin
            state_d      = StIdle;
            frame_done_d = (addr_q == LastAddr);
        end

        if (accept) begin
            if (pix_sof) begin
                // Restart the frame; any partial word is discarded.
                pack_d        = {31'b0, pix_data};
                bit_cnt_d     = 5'd1;
                pack_addr_d   = '0;
                short_frame_d = (bit_cnt_q != 5'd0) || (pack_addr_q != '0);
            end else begin
                pack_d[bit_cnt_q] = pix_data;
                bit_cnt_d         = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    state_d     = StPend;
                    wdata_d     = {pix_data, pack_q[30:0]};
                    addr_d      = pack_addr_q;
                    pack_addr_d = (pack_addr_q == LastAddr) ? '0 : pack_addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            pack_q        <= '0;
            bit_cnt_q     <= '0;
            pack_addr_q   <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pack_q        <= pack_d;
            bit_cnt_q     <= bit_cnt_d;
            pack_addr_q   <= pack_addr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
        end
    end

    assign fb_write     = (state_q == StPend);
    assign fb_address   = addr_q;
    assign fb_writedata = wdata_q;
    assign frame_done   = frame_done_q;
    assign short_frame  = short_frame_q;

endmodule
